// File: rtl/servo_motion_sequencer.sv
// Slew-limited four-joint servo sequencer: buffers one target command and walks
// one joint at a time toward its target, one degree per STEP_TICKS cycles.
module servo_motion_sequencer #(
  parameter int STEP_TICKS   = 50000,
  parameter int SETTLE_TICKS = 500000,
  parameter int HOME_ANGLE   = 90,
  parameter int MAX_ANGLE    = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_joint,
  input  logic [7:0] cmd_angle,
  output logic [7:0] angle1,
  output logic [7:0] angle2,
  output logic [7:0] angle3,
  output logic [7:0] angle4,
  output logic       busy,
  output logic [1:0] active_joint,
  output logic       move_done
);

  typedef enum logic [1:0] {IDLE, SELECT, MOVE, SETTLE} state_t;

  localparam logic [7:0]  HOME        = 8'(HOME_ANGLE);
  localparam logic [7:0]  MAX         = 8'(MAX_ANGLE);
  localparam logic [31:0] STEP_LAST   = 32'(STEP_TICKS - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_TICKS - 1);

  state_t      state;
  logic [7:0]  cur [4];
  logic [7:0]  tgt [4];
  logic        buf_valid;
  logic [1:0]  buf_joint;
  logic [7:0]  buf_angle;
  logic [1:0]  act;
  logic [1:0]  last;
  logic [31:0] tick;
  logic        done_q;

  logic        accept;
  logic        drain;
  logic        any_pending;
  logic [3:0]  pend_eff;
  logic [7:0]  tgt_eff;
  logic [1:0]  scan_idx;
  logic [1:0]  pick;
  logic        pick_ok;
  logic [7:0]  step_val;

  // Handshake: a command transfers on any cycle where cmd_valid and cmd_ready are
  // both high; cmd_ready is the registered "buffer empty" flag, never a function of cmd_valid.
  assign accept = cmd_valid && !buf_valid;
  // The active joint's target is frozen while it moves or settles.
  assign drain  = buf_valid && (state == IDLE || state == SELECT || buf_joint != act);

  always_comb begin
    any_pending = 1'b0;
    pend_eff    = 4'b0;
    tgt_eff     = 8'd0;
    for (int j = 0; j < 4; j++) begin
      tgt_eff     = (drain && buf_joint == 2'(j)) ? buf_angle : tgt[j];
      pend_eff[j] = (cur[j] != tgt_eff);
      any_pending = any_pending | (cur[j] != tgt[j]);
    end
  end

  // SELECT arbitrates on targets including one draining this cycle, so a command
  // that lands alongside the pick still gets its round-robin turn.
  always_comb begin
    pick     = last + 2'd1;
    pick_ok  = 1'b0;
    scan_idx = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last + 2'(k);
      if (!pick_ok && pend_eff[scan_idx]) begin
        pick    = scan_idx;
        pick_ok = 1'b1;
      end
    end
  end

  assign step_val = (cur[act] < tgt[act]) ? cur[act] + 8'd1 : cur[act] - 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 4; j++) begin
        cur[j] <= HOME;
        tgt[j] <= HOME;
      end
      state     <= IDLE;
      buf_valid <= 1'b0;
      buf_joint <= 2'd0;
      buf_angle <= 8'd0;
      act       <= 2'd0;
      last      <= 2'd3;
      tick      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        buf_valid <= 1'b1;
        buf_joint <= cmd_joint;
        buf_angle <= (cmd_angle > MAX) ? MAX : cmd_angle;
      end else if (drain) begin
        tgt[buf_joint] <= buf_angle;
        buf_valid      <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (any_pending) state <= SELECT;
        end
        SELECT: begin
          tick <= 32'd0;
          if (pick_ok) begin
            act   <= pick;
            state <= MOVE;
          end else begin
            state <= IDLE;
          end
        end
        MOVE: begin
          if (tick == STEP_LAST) begin
            tick     <= 32'd0;
            cur[act] <= step_val;
            if (step_val == tgt[act]) state <= SETTLE;
          end else begin
            tick <= tick + 32'd1;
          end
        end
        SETTLE: begin
          if (tick == SETTLE_LAST) begin
            tick   <= 32'd0;
            done_q <= 1'b1;
            last   <= act;
            state  <= IDLE;
          end else begin
            tick <= tick + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready    = !buf_valid;
  assign angle1       = cur[0];
  assign angle2       = cur[1];
  assign angle3       = cur[2];
  assign angle4       = cur[3];
  assign busy         = (state != IDLE);
  assign active_joint = act;
  assign move_done    = done_q;

endmodule
